// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared c16 register-file types: widths, register address, and the write-back request
// that the arbiter queues and drives onto the register file write port.
package regfile_wb_arbiter_pkg;

    localparam int DATA_W   = 16;
    localparam int RADDR_W  = 3;
    localparam int NUM_REGS = 2 ** RADDR_W;

    typedef logic [RADDR_W-1:0]  reg_addr_t;
    typedef logic [DATA_W-1:0]   reg_data_t;
    typedef logic [NUM_REGS-1:0] reg_mask_t;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t value;
    } wb_req_t;

    // One-hot mask selecting a single register, used to set/clear scoreboard bits.
    function automatic reg_mask_t reg_bit(input reg_addr_t a);
        reg_mask_t m;
        m    = '0;
        m[a] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus between the executor/load-MUL unit/decoder and the register-file write-back arbiter.
// The master drives requests and decode addresses; the slave (the arbiter) answers.
interface regfile_wb_arbiter_if #(
    parameter int QDEPTH = 2
);
    import regfile_wb_arbiter_pkg::*;

    localparam int CNT_W = $clog2(QDEPTH) + 1;

    // Executor write: fire-and-forget, always taken in the cycle ex_valid is high.
    logic      ex_valid;
    reg_addr_t ex_dest;
    reg_data_t ex_value;

    // Decode issue of a multi-cycle op marks its destination pending.
    logic      un_issue;
    reg_addr_t un_issue_dest;

    // Unit result handshake: a transfer happens on a rising clk edge where un_valid and
    // un_ready are both high. un_ready depends only on queue occupancy, never on un_valid,
    // and the unit must hold dest/value stable while un_valid is high without un_ready.
    logic      un_valid;
    logic      un_ready;
    reg_addr_t un_dest;
    reg_data_t un_value;

    reg_addr_t dec_ra;
    reg_addr_t dec_rb;
    reg_addr_t dec_rd;
    logic      dec_uses_rb;

    logic             stall;
    logic             ex_hold;
    logic             wr_enable;
    reg_addr_t        wr_addr;
    reg_data_t        wr_value;
    reg_mask_t        pending;
    logic [CNT_W-1:0] q_count;

    modport master (
        output ex_valid, ex_dest, ex_value,
        output un_issue, un_issue_dest,
        output un_valid, un_dest, un_value,
        output dec_ra, dec_rb, dec_rd, dec_uses_rb,
        input  un_ready, stall, ex_hold,
        input  wr_enable, wr_addr, wr_value, pending, q_count
    );

    modport slave (
        input  ex_valid, ex_dest, ex_value,
        input  un_issue, un_issue_dest,
        input  un_valid, un_dest, un_value,
        input  dec_ra, dec_rb, dec_rd, dec_uses_rb,
        output un_ready, stall, ex_hold,
        output wr_enable, wr_addr, wr_value, pending, q_count
    );

endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Small circular queue of pending unit write-backs; DEPTH must be a power of two >= 2
// so the pointers wrap by plain overflow.
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  wb_req_t                i_data,
    input  logic                   i_pop,
    output wb_req_t                o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_req_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Single register-file write port shared by the executor (always wins) and the load/MUL unit
// (queued); also tracks outstanding unit destinations and stalls decode on hazards against them.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int QDEPTH     = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int CNT_W    = $clog2(QDEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    wb_req_t          w_push_req;
    wb_req_t          w_head;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_push;
    logic             w_pop;
    reg_mask_t        w_pending_nxt;
    logic             w_stall;

    logic                r_wr_enable;
    reg_addr_t           r_wr_addr;
    reg_data_t           r_wr_value;
    reg_mask_t           r_pending;
    logic [STARVE_W-1:0] r_starve;
    logic                r_ex_hold;

    // A unit result accepted this edge is not visible at the head until next cycle,
    // which gives the two-cycle accept-to-write latency.
    assign w_push_req.addr  = bus.un_dest;
    assign w_push_req.value = bus.un_value;
    assign w_push           = bus.un_valid & ~w_full;
    assign w_pop            = ~bus.ex_valid & ~w_empty;

    wb_fifo #(
        .DEPTH (QDEPTH)
    ) u_wb_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_enable <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_value  <= '0;
        end else begin
            r_wr_enable <= bus.ex_valid | ~w_empty;
            if (bus.ex_valid) begin
                r_wr_addr  <= bus.ex_dest;
                r_wr_value <= bus.ex_value;
            end else if (~w_empty) begin
                r_wr_addr  <= w_head.addr;
                r_wr_value <= w_head.value;
            end
        end
    end

    // A new issue to the register being retired keeps it pending: the set is applied last.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_pop) begin
            w_pending_nxt = w_pending_nxt & ~reg_bit(w_head.addr);
        end
        if (bus.un_issue) begin
            w_pending_nxt = w_pending_nxt | reg_bit(bus.un_issue_dest);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // Non-empty without a pop can only mean the executor took the port this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve  <= '0;
            r_ex_hold <= 1'b0;
        end else begin
            if (w_empty || w_pop) begin
                r_starve <= '0;
            end else if (r_starve != STARVE_W'(STARVE_MAX)) begin
                r_starve <= r_starve + 1'b1;
            end
            r_ex_hold <= (r_starve >= STARVE_W'(STARVE_MAX));
        end
    end

    always_comb begin
        w_stall = r_pending[bus.dec_ra]
                | (bus.dec_uses_rb & r_pending[bus.dec_rb])
                | r_pending[bus.dec_rd]
                | (bus.un_issue & w_full);
    end

    assign bus.un_ready  = ~w_full;
    assign bus.stall     = w_stall;
    assign bus.ex_hold   = r_ex_hold;
    assign bus.wr_enable = r_wr_enable;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_value  = r_wr_value;
    assign bus.pending   = r_pending;
    assign bus.q_count   = w_count;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for the write-back arbiter: expected register writes are queued as stimulus
// is issued and a negedge monitor retires them against the write port.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int QDEPTH     = 2;
    localparam int STARVE_MAX = 4;
    localparam int EXP_W      = RADDR_W + DATA_W;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [EXP_W-1:0] exp_q[$];

    regfile_wb_arbiter_if #(.QDEPTH(QDEPTH)) bus();

    regfile_wb_arbiter #(
        .QDEPTH     (QDEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input reg_addr_t a, input reg_data_t v);
        exp_q.push_back({a, v});
    endtask

    task automatic drive_ex(input logic v, input reg_addr_t d, input reg_data_t val, input bit lands);
        bus.ex_valid = v;
        bus.ex_dest  = d;
        bus.ex_value = val;
        if (v && lands) expect_wr(d, val);
    endtask

    task automatic drive_un(input logic v, input reg_addr_t d, input reg_data_t val);
        bus.un_valid = v;
        bus.un_dest  = d;
        bus.un_value = val;
    endtask

    task automatic issue(input logic v, input reg_addr_t d);
        bus.un_issue      = v;
        bus.un_issue_dest = d;
    endtask

    task automatic set_dec(input reg_addr_t ra, input reg_addr_t rb, input reg_addr_t rd, input logic use_rb);
        bus.dec_ra      = ra;
        bus.dec_rb      = rb;
        bus.dec_rd      = rd;
        bus.dec_uses_rb = use_rb;
    endtask

    task automatic drive_idle();
        drive_ex(1'b0, '0, '0, 1'b0);
        drive_un(1'b0, '0, '0);
        issue(1'b0, '0);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic [EXP_W-1:0] act;
        logic [EXP_W-1:0] exp;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && bus.wr_enable === 1'b1) begin
                act = {bus.wr_addr, bus.wr_value};
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0d value 0x%0h, required no write",
                             bus.wr_addr, bus.wr_value);
                end else begin
                    exp = exp_q.pop_front();
                    chk("wb_write", 32'(act), 32'(exp));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin : main
        drive_idle();
        set_dec('0, '0, '0, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_wr_enable", 32'(bus.wr_enable), 0);
        chk("rst_wr_addr",   32'(bus.wr_addr),   0);
        chk("rst_wr_value",  32'(bus.wr_value),  0);
        chk("rst_pending",   32'(bus.pending),   0);
        chk("rst_q_count",   32'(bus.q_count),   0);
        chk("rst_ex_hold",   32'(bus.ex_hold),   0);
        chk("rst_un_ready",  32'(bus.un_ready),  1);
        @(posedge clk);
        #1 reset = 1'b0;
        mid();

        // 1: executor write lands exactly one cycle later, for one cycle
        next_cycle(); drive_ex(1'b1, 3'd3, 16'h1234, 1'b1);
        mid(); chk("t1_no_write_yet", 32'(bus.wr_enable), 0);
        next_cycle(); drive_ex(1'b0, '0, '0, 1'b0);
        mid(); chk("t1_wr_enable", 32'(bus.wr_enable), 1);
        next_cycle();
        mid(); chk("t1_single_cycle", 32'(bus.wr_enable), 0);

        // 2: RAW stall on pending r5, unit result retires it two cycles after accept
        next_cycle(); issue(1'b1, 3'd5);
        mid();
        next_cycle(); issue(1'b0, '0); set_dec(3'd5, '0, '0, 1'b0);
        drive_un(1'b1, 3'd5, 16'hBEEF); expect_wr(3'd5, 16'hBEEF);
        mid(); chk("t2_pending_set", 32'(bus.pending), 32'h20);
        chk("t2_stall_ra", 32'(bus.stall), 1);
        next_cycle(); drive_un(1'b0, '0, '0);
        mid(); chk("t2_queued", 32'(bus.q_count), 1);
        chk("t2_not_written_yet", 32'(bus.wr_enable), 0);
        chk("t2_stall_held", 32'(bus.stall), 1);
        set_dec('0, 3'd5, '0, 1'b0); #1 chk("t2_rb_unused", 32'(bus.stall), 0);
        set_dec('0, 3'd5, '0, 1'b1); #1 chk("t2_stall_rb", 32'(bus.stall), 1);
        set_dec('0, '0, 3'd5, 1'b0); #1 chk("t2_stall_rd", 32'(bus.stall), 1);
        set_dec(3'd5, '0, '0, 1'b0);
        next_cycle();
        mid(); chk("t2_written", 32'(bus.wr_enable), 1);
        chk("t2_pending_clear", 32'(bus.pending), 0);
        chk("t2_stall_drop", 32'(bus.stall), 0);
        set_dec('0, '0, '0, 1'b0);

        // 3: queued entry starved by back-to-back executor writes
        next_cycle(); issue(1'b1, 3'd6); drive_un(1'b1, 3'd6, 16'h0606);
        drive_ex(1'b1, 3'd1, 16'h1000, 1'b1);
        mid();
        next_cycle(); issue(1'b0, '0); drive_un(1'b0, '0, '0);
        drive_ex(1'b1, 3'd1, 16'h1001, 1'b1);
        mid(); chk("t3_queued", 32'(bus.q_count), 1);
        next_cycle(); drive_ex(1'b1, 3'd1, 16'h1002, 1'b1);
        mid(); chk("t3_hold_early", 32'(bus.ex_hold), 0);
        for (int i = 3; i < 10; i++) begin
            next_cycle(); drive_ex(1'b1, 3'd1, reg_data_t'(32'h1000 + i), 1'b1);
            mid();
        end
        chk("t3_ex_hold", 32'(bus.ex_hold), 1);
        chk("t3_still_queued", 32'(bus.q_count), 1);
        chk("t3_pending", 32'(bus.pending), 32'h40);
        next_cycle(); drive_ex(1'b0, '0, '0, 1'b0); expect_wr(3'd6, 16'h0606);
        mid();
        next_cycle();
        mid(); chk("t3_drain_write", 32'(bus.wr_enable), 1);
        chk("t3_drained", 32'(bus.q_count), 0);
        next_cycle();
        mid(); chk("t3_hold_release", 32'(bus.ex_hold), 0);
        chk("t3_pending_clear", 32'(bus.pending), 0);

        // 4: fill the queue while the executor owns the port
        next_cycle(); drive_ex(1'b1, 3'd2, 16'h2000, 1'b1); drive_un(1'b1, 3'd4, 16'h4444);
        mid();
        next_cycle(); drive_ex(1'b1, 3'd2, 16'h2001, 1'b1); drive_un(1'b1, 3'd7, 16'h7777);
        mid(); chk("t4_ready_one", 32'(bus.un_ready), 1);
        issue(1'b1, 3'd3); #1 chk("t4_issue_not_full", 32'(bus.stall), 0);
        issue(1'b0, '0);
        next_cycle(); drive_ex(1'b1, 3'd2, 16'h2002, 1'b1); drive_un(1'b1, 3'd0, 16'hDEAD);
        mid(); chk("t4_not_ready", 32'(bus.un_ready), 0);
        chk("t4_full", 32'(bus.q_count), 2);
        issue(1'b1, 3'd3); #1 chk("t4_issue_full_stall", 32'(bus.stall), 1);
        issue(1'b0, '0);
        next_cycle(); drive_ex(1'b1, 3'd2, 16'h2003, 1'b1); drive_un(1'b0, '0, '0);
        mid(); chk("t4_third_rejected", 32'(bus.q_count), 2);
        next_cycle(); drive_ex(1'b0, '0, '0, 1'b0);
        expect_wr(3'd4, 16'h4444); expect_wr(3'd7, 16'h7777);
        mid(); chk("t4_no_hold", 32'(bus.ex_hold), 0);
        next_cycle();
        mid(); chk("t4_one_left", 32'(bus.q_count), 1);
        next_cycle();
        mid(); chk("t4_empty", 32'(bus.q_count), 0);

        // 5: retire and re-issue of r2 in the same cycle keeps it pending
        next_cycle(); issue(1'b1, 3'd2); drive_un(1'b1, 3'd2, 16'h2222); expect_wr(3'd2, 16'h2222);
        mid();
        next_cycle(); issue(1'b1, 3'd2); drive_un(1'b0, '0, '0);
        mid(); chk("t5_pending_before", 32'(bus.pending), 32'h04);
        chk("t5_queued", 32'(bus.q_count), 1);
        next_cycle(); issue(1'b0, '0);
        mid(); chk("t5_set_wins", 32'(bus.pending), 32'h04);
        chk("t5_written", 32'(bus.wr_enable), 1);

        // 6: async reset with two queued entries and r2/r5 pending
        next_cycle(); drive_ex(1'b1, 3'd1, 16'h5555, 1'b1); issue(1'b1, 3'd5);
        drive_un(1'b1, 3'd5, 16'h0555);
        mid();
        next_cycle(); drive_ex(1'b1, 3'd1, 16'h5556, 1'b1); issue(1'b0, '0);
        drive_un(1'b1, 3'd2, 16'h0222);
        mid();
        next_cycle(); drive_ex(1'b1, 3'd1, 16'h5557, 1'b0); drive_un(1'b0, '0, '0);
        mid(); chk("t6_full", 32'(bus.q_count), 2);
        chk("t6_pending", 32'(bus.pending), 32'h24);
        #1 reset = 1'b1;
        drive_idle();
        #1;
        chk("t6_rst_q_count",   32'(bus.q_count),   0);
        chk("t6_rst_pending",   32'(bus.pending),   0);
        chk("t6_rst_wr_enable", 32'(bus.wr_enable), 0);
        chk("t6_rst_ex_hold",   32'(bus.ex_hold),   0);
        chk("t6_rst_un_ready",  32'(bus.un_ready),  1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mid(); chk("t6_no_write", 32'(bus.wr_enable), 0);
            next_cycle();
        end
        mid(); chk("t6_q_after", 32'(bus.q_count), 0);
        chk("t6_pending_after", 32'(bus.pending), 0);

        chk("exp_q_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
